mips_multicycle_control: RTL and testbench

Control FSM that drives the load/store/R/I datapath's control inputs (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALU_OP), replacing bench-driven control. It sits between Instruction_Fetch and the datapath. It latches the fetched word, decodes it, and sequences FETCH→DECODE→EXEC→MEM→WB. Register-file and memory writes each happen in exactly one cycle per instruction.

---
 rtl/mips_multicycle_control_pkg.sv | 32 +++
 rtl/mips_multicycle_control_decoder.sv | 59 +++++
 rtl/mips_multicycle_control.sv | 134 +++++++++++++
 tb/tb_mips_multicycle_control.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared opcode/funct codes, ALU operation codes and FSM state encoding
// for the multicycle MIPS control unit.
package mips_multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

endpackage

// File: rtl/mips_multicycle_control_decoder.sv
// Combinational instruction decoder: opcode/funct to datapath controls
// plus legality and load/store class.
module mips_decoder
    import mips_multicycle_control_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic       o_legal,
    output logic       o_is_load,
    output logic       o_is_store,
    output logic [3:0] o_alu_op,
    output logic       o_alusrc,
    output logic       o_regdst,
    output logic       o_memtoreg
);

    always_comb begin
        o_legal    = 1'b1;
        o_is_load  = 1'b0;
        o_is_store = 1'b0;
        o_alu_op   = ALU_ADD;
        o_alusrc   = 1'b0;
        o_regdst   = 1'b0;
        o_memtoreg = 1'b0;
        case (i_opcode)
            OP_LW: begin
                o_is_load  = 1'b1;
                o_alusrc   = 1'b1;
                o_memtoreg = 1'b1;
            end
            OP_SW: begin
                o_is_store = 1'b1;
                o_alusrc   = 1'b1;
            end
            OP_ADDI: o_alusrc = 1'b1;
            OP_ANDI: begin
                o_alusrc = 1'b1;
                o_alu_op = ALU_AND;
            end
            OP_ORI: begin
                o_alusrc = 1'b1;
                o_alu_op = ALU_OR;
            end
            OP_RTYPE: begin
                o_regdst = 1'b1;
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_SLT:  o_alu_op = ALU_SLT;
                    default: o_legal  = 1'b0;
                endcase
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle control FSM: latches the fetched word, decodes it and sequences
// FETCH/DECODE/EXEC/MEM/WB, driving one-shot strobes and held datapath controls.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [N-1:0]     instruction,
    output logic             pc_en,
    output logic             ir_load,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             RegDst,
    output logic [3:0]       ALU_OP,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_ir;
    logic             r_armed;
    logic             r_is_load;
    logic             r_is_store;
    logic [3:0]       r_alu_op;
    logic             r_alusrc;
    logic             r_regdst;
    logic             r_memtoreg;
    logic [CNT_W-1:0] r_retired;

    logic             w_legal;
    logic             w_is_load;
    logic             w_is_store;
    logic [3:0]       w_alu_op;
    logic             w_alusrc;
    logic             w_regdst;
    logic             w_memtoreg;
    logic             w_retire;
    logic             w_unused_ir;

    mips_decoder u_decoder (
        .i_opcode   (r_ir[31:26]),
        .i_funct    (r_ir[5:0]),
        .o_legal    (w_legal),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store),
        .o_alu_op   (w_alu_op),
        .o_alusrc   (w_alusrc),
        .o_regdst   (w_regdst),
        .o_memtoreg (w_memtoreg)
    );

    // Register fields are consumed by the datapath, not by this unit.
    assign w_unused_ir = ^r_ir;

    // r_armed keeps the first cycle after reset silent while sitting in FETCH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (!stall) begin
                r_state <= w_next;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (r_armed) w_next = S_DECODE;
            S_DECODE: w_next = w_legal ? S_EXEC : S_FETCH;
            S_EXEC:   w_next = (r_is_load || r_is_store) ? S_MEM : S_WB;
            S_MEM:    w_next = r_is_store ? S_FETCH : S_WB;
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    assign w_retire = ((r_state == S_MEM) && r_is_store) || (r_state == S_WB);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ir       <= '0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_alu_op   <= ALU_ADD;
            r_alusrc   <= 1'b0;
            r_regdst   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_retired  <= '0;
        end else if (!stall) begin
            if ((r_state == S_FETCH) && r_armed) begin
                r_ir <= instruction;
            end
            if ((r_state == S_DECODE) && w_legal) begin
                r_is_load  <= w_is_load;
                r_is_store <= w_is_store;
                r_alu_op   <= w_alu_op;
                r_alusrc   <= w_alusrc;
                r_regdst   <= w_regdst;
                r_memtoreg <= w_memtoreg;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ir_load  = (r_state == S_FETCH) && r_armed && !stall;
        pc_en    = (r_state == S_DECODE) && !stall;
        illegal  = (r_state == S_DECODE) && !w_legal && !stall;
        MemRead  = r_is_load && ((r_state == S_MEM) || (r_state == S_WB));
        MemWrite = (r_state == S_MEM) && r_is_store && !stall;
        RegWrite = (r_state == S_WB) && !stall;
        MemtoReg = r_memtoreg;
        ALUSrc   = r_alusrc;
        RegDst   = r_regdst;
        ALU_OP   = r_alu_op;
        retired  = r_retired;
        state    = r_state;
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: each driven cycle pushes its hand-computed expected
// outputs; a negedge monitor pops and compares.
module tb_mips_multicycle_control;

    localparam logic [31:0] I_LW   = 32'h8C410001;
    localparam logic [31:0] I_SW   = 32'hACA50002;
    localparam logic [31:0] I_ADD  = 32'h00018020;
    localparam logic [31:0] I_SUB  = 32'h0128A822;
    localparam logic [31:0] I_ILL  = 32'hFC000000;
    localparam logic [31:0] I_ADDI = 32'h20110014;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instruction = '0;
    logic        pc_en, ir_load, RegWrite, MemRead, MemWrite, MemtoReg;
    logic        ALUSrc, RegDst, illegal;
    logic [3:0]  ALU_OP;
    logic [31:0] retired;
    logic [2:0]  state;

    typedef struct {
        int          idx;
        logic [15:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cyc    = 0;

    mips_multicycle_control #(.N(32), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .instruction (instruction),
        .pc_en       (pc_en),
        .ir_load     (ir_load),
        .RegWrite    (RegWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrc      (ALUSrc),
        .RegDst      (RegDst),
        .ALU_OP      (ALU_OP),
        .illegal     (illegal),
        .retired     (retired),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs and queue the outputs expected during it.
    task automatic cyc(input logic r, input logic s, input logic [31:0] ins,
                       input logic [2:0] st, input logic pc, input logic irl,
                       input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic as, input logic rd,
                       input logic [3:0] aop, input logic ill, input int ret);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        stall = s;
        instruction = ins;
        n_cyc++;
        e.idx = n_cyc;
        e.ctl = {st, pc, irl, rw, mr, mw, m2r, as, rd, aop, ill};
        e.ret = ret;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = q.pop_front();
            act = {state, pc_en, ir_load, RegWrite, MemRead, MemWrite, MemtoReg,
                   ALUSrc, RegDst, ALU_OP, illegal};
            n_checks++;
            if (act !== e.ctl || retired !== e.ret) begin
                n_fail++;
                $display("FAIL cyc%0d: ctl got %b want %b, retired got %0d want %0d",
                         e.idx, act, e.ctl, retired, e.ret);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //   r  s  instr   st pc irl rw mr mw m2r as rd aop   ill ret
        cyc(0, 0, '0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h2, 0, 0);
        cyc(1, 0, I_LW,   0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h2, 0, 0);
        cyc(1, 0, I_LW,   0, 0, 1, 0, 0, 0, 0, 0, 0, 4'h2, 0, 0);
        cyc(1, 0, I_LW,   1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h2, 0, 0);
        cyc(1, 0, I_LW,   2, 0, 0, 0, 0, 0, 1, 1, 0, 4'h2, 0, 0);
        cyc(1, 0, I_LW,   3, 0, 0, 0, 1, 0, 1, 1, 0, 4'h2, 0, 0);
        cyc(1, 0, I_LW,   4, 0, 0, 1, 1, 0, 1, 1, 0, 4'h2, 0, 0);
        // sw
        cyc(1, 0, I_SW,   0, 0, 1, 0, 0, 0, 1, 1, 0, 4'h2, 0, 1);
        cyc(1, 0, I_SW,   1, 1, 0, 0, 0, 0, 1, 1, 0, 4'h2, 0, 1);
        cyc(1, 0, I_SW,   2, 0, 0, 0, 0, 0, 0, 1, 0, 4'h2, 0, 1);
        cyc(1, 0, I_SW,   3, 0, 0, 0, 0, 1, 0, 1, 0, 4'h2, 0, 1);
        // add then sub
        cyc(1, 0, I_ADD,  0, 0, 1, 0, 0, 0, 0, 1, 0, 4'h2, 0, 2);
        cyc(1, 0, I_ADD,  1, 1, 0, 0, 0, 0, 0, 1, 0, 4'h2, 0, 2);
        cyc(1, 0, I_ADD,  2, 0, 0, 0, 0, 0, 0, 0, 1, 4'h2, 0, 2);
        cyc(1, 0, I_ADD,  4, 0, 0, 1, 0, 0, 0, 0, 1, 4'h2, 0, 2);
        cyc(1, 0, I_SUB,  0, 0, 1, 0, 0, 0, 0, 0, 1, 4'h2, 0, 3);
        cyc(1, 0, I_SUB,  1, 1, 0, 0, 0, 0, 0, 0, 1, 4'h2, 0, 3);
        cyc(1, 0, I_SUB,  2, 0, 0, 0, 0, 0, 0, 0, 1, 4'h6, 0, 3);
        cyc(1, 0, I_SUB,  4, 0, 0, 1, 0, 0, 0, 0, 1, 4'h6, 0, 3);
        // illegal then addi
        cyc(1, 0, I_ILL,  0, 0, 1, 0, 0, 0, 0, 0, 1, 4'h6, 0, 4);
        cyc(1, 0, I_ILL,  1, 1, 0, 0, 0, 0, 0, 0, 1, 4'h6, 1, 4);
        cyc(1, 0, I_ADDI, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4'h6, 0, 4);
        cyc(1, 0, I_ADDI, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'h6, 0, 4);
        cyc(1, 0, I_ADDI, 2, 0, 0, 0, 0, 0, 0, 1, 0, 4'h2, 0, 4);
        cyc(1, 0, I_ADDI, 4, 0, 0, 1, 0, 0, 0, 1, 0, 4'h2, 0, 4);
        // lw stalled three cycles in WB
        cyc(1, 0, I_LW,   0, 0, 1, 0, 0, 0, 0, 1, 0, 4'h2, 0, 5);
        cyc(1, 0, I_LW,   1, 1, 0, 0, 0, 0, 0, 1, 0, 4'h2, 0, 5);
        cyc(1, 0, I_LW,   2, 0, 0, 0, 0, 0, 1, 1, 0, 4'h2, 0, 5);
        cyc(1, 0, I_LW,   3, 0, 0, 0, 1, 0, 1, 1, 0, 4'h2, 0, 5);
        cyc(1, 1, I_LW,   4, 0, 0, 0, 1, 0, 1, 1, 0, 4'h2, 0, 5);
        cyc(1, 1, I_LW,   4, 0, 0, 0, 1, 0, 1, 1, 0, 4'h2, 0, 5);
        cyc(1, 1, I_LW,   4, 0, 0, 0, 1, 0, 1, 1, 0, 4'h2, 0, 5);
        cyc(1, 0, I_LW,   4, 0, 0, 1, 1, 0, 1, 1, 0, 4'h2, 0, 5);
        // stall in FETCH, then sw reset in MEM
        cyc(1, 1, I_SW,   0, 0, 0, 0, 0, 0, 1, 1, 0, 4'h2, 0, 6);
        cyc(1, 0, I_SW,   0, 0, 1, 0, 0, 0, 1, 1, 0, 4'h2, 0, 6);
        cyc(1, 0, I_SW,   1, 1, 0, 0, 0, 0, 1, 1, 0, 4'h2, 0, 6);
        cyc(1, 0, I_SW,   2, 0, 0, 0, 0, 0, 0, 1, 0, 4'h2, 0, 6);
        cyc(0, 1, I_SW,   3, 0, 0, 0, 0, 0, 0, 1, 0, 4'h2, 0, 6);
        cyc(1, 0, I_SW,   0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h2, 0, 0);
        cyc(1, 0, I_SW,   0, 0, 1, 0, 0, 0, 0, 0, 0, 4'h2, 0, 0);

        @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: queue depth got %0d want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
